// File: rtl/alu_16b_arbiter.sv
// Round-robin two-client arbiter/sequencer for a shared registered 16-bit ALU.
// Optional divide-by-zero rejection is enabled by defining ALU_ARB_DIV0_CHECK_EN.
module alu_16b_arbiter #(
  parameter int DATA_W  = 16,
  parameter int FUN_W   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0_VALID,
  input  logic              REQ1_VALID,
  output logic              REQ0_READY,
  output logic              REQ1_READY,
  input  logic [DATA_W-1:0] REQ0_A,
  input  logic [DATA_W-1:0] REQ0_B,
  input  logic [DATA_W-1:0] REQ1_A,
  input  logic [DATA_W-1:0] REQ1_B,
  input  logic [FUN_W-1:0]  REQ0_FUN,
  input  logic [FUN_W-1:0]  REQ1_FUN,
  output logic              RSP0_VALID,
  output logic              RSP1_VALID,
  input  logic              RSP0_READY,
  input  logic              RSP1_READY,
  output logic [DATA_W-1:0] RSP_OUT,
  output logic [4:0]        RSP_FLAGS,
  output logic              RSP_ERR,
  output logic              BUSY,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [FUN_W-1:0]  ALU_FUN,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic              Carry_Flag,
  input  logic              Arith_Flag,
  input  logic              Logic_Flag,
  input  logic              CMP_Flag,
  input  logic              Shift_Flag
);

  localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_nx;
  logic               last_grant;
  logic               owner;
  logic               grant;
  logic               accept;
  logic               rsp_hs;
  logic               div0;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  op_a, op_b;
  logic [FUN_W-1:0]   op_fun;
  logic [DATA_W-1:0]  sel_a, sel_b;
  logic [FUN_W-1:0]   sel_fun;
  logic [DATA_W-1:0]  rsp_out_q;
  logic [4:0]         rsp_flags_q;

  // Grant is 1 only when client 1 alone is valid, or both are valid and client 0 went last.
  always_comb begin
    grant = 1'b0;
    if (REQ0_VALID && REQ1_VALID) grant = ~last_grant;
    else if (REQ1_VALID)          grant = 1'b1;
    accept  = (state == IDLE) && (REQ0_VALID || REQ1_VALID) && !RST;
    sel_a   = grant ? REQ1_A   : REQ0_A;
    sel_b   = grant ? REQ1_B   : REQ0_B;
    sel_fun = grant ? REQ1_FUN : REQ0_FUN;
  end

`ifdef ALU_ARB_DIV0_CHECK_EN
  assign div0 = (sel_fun == FUN_W'(3)) && (sel_b == '0);
`else
  assign div0 = 1'b0;
`endif

  assign REQ0_READY = accept && !grant;
  assign REQ1_READY = accept && grant;
  assign RSP0_VALID = (state == RESP) && !owner;
  assign RSP1_VALID = (state == RESP) && owner;
  assign rsp_hs     = owner ? RSP1_READY : RSP0_READY;
  assign BUSY       = (state != IDLE);
  assign ALU_A      = op_a;
  assign ALU_B      = op_b;
  assign ALU_FUN    = op_fun;
  assign RSP_OUT    = rsp_out_q;
  assign RSP_FLAGS  = rsp_flags_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = div0 ? RESP : EXEC;
      EXEC: if (cnt == '0) state_nx = RESP;
      RESP: if (rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand registers change only on an issued acceptance, so the ALU inputs stay quiet otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      cnt         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_fun      <= '0;
      rsp_out_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
        cnt        <= CNT_W'(ALU_LAT);
        if (div0) begin
          rsp_out_q   <= '0;
          rsp_flags_q <= '0;
        end else begin
          op_a   <= sel_a;
          op_b   <= sel_b;
          op_fun <= sel_fun;
        end
      end
      if (state == EXEC) begin
        if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end else begin
          rsp_out_q   <= ALU_OUT;
          rsp_flags_q <= {Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
        end
      end
    end
  end

`ifdef ALU_ARB_DIV0_CHECK_EN
  logic rsp_err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_err_q <= 1'b0;
    end else begin
      if (accept)                          rsp_err_q <= div0;
      else if (state == EXEC && cnt == '0) rsp_err_q <= 1'b0;
    end
  end

  assign RSP_ERR = rsp_err_q;
`else
  assign RSP_ERR = 1'b0;
`endif

endmodule

// File: doc/alu_16b_arbiter.md
# alu_16b_arbiter

Two-requester arbiter and sequencer for the shared registered 16-bit ALU (`ALU_16B`). It accepts operation requests (A, B, ALU_FUN) from two clients over valid/ready handshakes and grants them round-robin. It holds the granted operands on the ALU inputs for the ALU's pipeline latency, then returns ALU_OUT and the five flags to the owning requester over a response valid/ready handshake. It sits between client blocks and a single `ALU_16B` instance.

## Interface
- `DATA_W`, 16, operand/result width
- `FUN_W`, 4, ALU function code width
- `ALU_LAT`, 1, CLK edges from stable ALU inputs to valid ALU_OUT/flags (≥1)

Ports:
- `CLK` in 1: single clock, rising edge
- `RST` in 1: reset, synchronous, active-high
- `REQ0_VALID`, `REQ1_VALID` in 1: request valid per client
- `REQ0_READY`, `REQ1_READY` out 1: request accepted (combinational)
- `REQ0_A`, `REQ0_B`, `REQ1_A`, `REQ1_B` in DATA_W: operands
- `REQ0_FUN`, `REQ1_FUN` in FUN_W: ALU function code
- `RSP0_VALID`, `RSP1_VALID` out 1: response valid to owning client
- `RSP0_READY`, `RSP1_READY` in 1: client takes response
- `RSP_OUT` out DATA_W: result, shared by both clients, qualified by RSPn_VALID
- `RSP_FLAGS` out 5: {Carry, Arith, Logic, CMP, Shift}
- `RSP_ERR` out 1: divide-by-zero rejected (see Configuration)
- `BUSY` out 1: state ≠ IDLE
- `ALU_A`, `ALU_B` out DATA_W; `ALU_FUN` out FUN_W: to ALU
- `ALU_OUT` in DATA_W; `Carry_Flag`, `Arith_Flag`, `Logic_Flag`, `CMP_Flag`, `Shift_Flag` in 1: from ALU

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any REQn_VALID, grant one client and assert REQn_READY for the granted client only, in the same cycle.
  - On that edge: capture A/B/FUN into the operand registers, record the owner, load the counter with ALU_LAT, and go to EXEC.
- **Round-robin arbitration**
  - `last_grant` resets to 1, so client 0 wins the first contention.
  - If only one client is valid, that client is granted.
  - If both are valid, the client ≠ last_grant is granted.
  - last_grant updates only on acceptance.
- **EXEC**
  - ALU_A/B/FUN are driven from the operand registers and held constant.
  - The counter decrements each cycle.
  - In the cycle where the counter = 0: capture ALU_OUT and the flags into the response registers, then go to RESP.
  - EXEC therefore lasts ALU_LAT+1 cycles.
- **RESP**
  - RSPn_VALID (owner only) is high and held, with RSP_OUT/RSP_FLAGS/RSP_ERR stable, until RSPn_READY.
  - On the edge where valid and ready are both high, go to IDLE.
  - No new request is accepted in RESP.
- ALU inputs keep their last issued values when idle. No extra toggling.
- The ALU result is passed through unmodified. No width change, and flags are not interpreted.
- Requests may drop REQn_VALID before acceptance. Nothing is latched unless the handshake occurs.

## Timing
- **Reset values:** state IDLE; REQn_READY 0; RSPn_VALID 0; RSP_OUT 0; RSP_FLAGS 0; RSP_ERR 0; BUSY 0; ALU_A/ALU_B/ALU_FUN 0; last_grant 1.
- **Latency:** accept at edge of cycle 0 → RSPn_VALID high in cycle ALU_LAT+2 (cycle 3 for ALU_LAT=1).
- **Peak throughput:** one operation per ALU_LAT+3 cycles, with RSPn_READY tied high.
- **Simultaneous events:**
  - Both valid in IDLE: resolved by round-robin.
  - A new request arriving during EXEC/RESP waits, with REQn_READY low.
  - A response accepted on the same edge a new request is presented: the new request is accepted in the following IDLE cycle, not the same edge.
- **RST mid-operation** (any state): the in-flight operation is dropped, no response is produced, and all outputs take their reset values next cycle.
- RSPn_READY while RSPn_VALID is low is ignored.

## Configuration
- Macro `ALU_ARB_DIV0_CHECK_EN`.
- **Defined:**
  - An accepted request with FUN = 4'b0011 and B = 0 is not issued: ALU_A/B/FUN stay unchanged.
  - The FSM goes IDLE → RESP directly.
  - The response is RSP_OUT = 0, RSP_FLAGS = 0, RSP_ERR = 1, with RSPn_VALID in cycle 1 after acceptance.
  - RSP_ERR = 0 for all other responses.
- **Undefined:**
  - Divide-by-zero is issued normally, with the standard latency and ALU result passthrough.
  - RSP_ERR is tied 0.

## Test plan
- **Reset:** RST high 2 cycles during EXEC. Required: all outputs 0, BUSY 0, no RSPn_VALID afterwards.
- **Single ADD:** client 0 sends A=6, B=7, FUN=0000, RSP0_READY=1. Required: RSP0_VALID in cycle 3 after accept, RSP_OUT=13, RSP1_VALID stays 0.
- **Contention:** both valid from reset; client 0 sends 6+7, client 1 sends SUB 15−4. Required:
  - Client 0 is granted first (13); client 1 is granted next (11).
  - A third simultaneous round goes to client 0.
- **Backpressure:** RSP1_READY low for 5 cycles on MUL 4×3. Required: RSP1_VALID held with RSP_OUT=12 stable, no new grant until accepted.
- **Compare op:** CMPG A=15, B=10 (FUN=1011). Required: RSP_OUT=2, RSP_FLAGS CMP bit=1.
- **Divide by zero:** DIV A=14, B=0.
  - Macro defined: RSP_ERR=1, RSP_OUT=0 one cycle after accept, ALU_FUN unchanged.
  - Macro undefined: RSP_OUT=ALU_OUT (0), RSP_ERR=0, in cycle 3.
